// File: rtl/hash_drbg_pkg.sv
// rtl/hash_drbg_pkg.sv - shared constants, state enums and message helpers for the Hash_DRBG stream
package hash_drbg_pkg;

    localparam int BLOCKSIZE    = 512;
    localparam int NBIT_SIZE    = 64;
    localparam int SEEDLEN      = 256;
    localparam int PERS_W       = BLOCKSIZE - SEEDLEN - NBIT_SIZE - 1;
    localparam int DERIVE_PAD_W = BLOCKSIZE - 8 - SEEDLEN - 1 - NBIT_SIZE;

    localparam logic [7:0] PREFIX_C      = 8'h00;
    localparam logic [7:0] PREFIX_RESEED = 8'h01;
    localparam logic [7:0] PREFIX_H      = 8'h03;

    localparam logic [NBIT_SIZE-1:0] LEN_SEED   = 64'd447;
    localparam logic [NBIT_SIZE-1:0] LEN_DERIVE = 64'd264;
    localparam logic [NBIT_SIZE-1:0] LEN_GEN    = 64'd256;

    typedef enum logic [3:0] {
        ST_SEED_V,
        ST_SEED_C,
        ST_IDLE,
        ST_GEN_HASH,
        ST_GEN_OUT,
        ST_UPD_H,
        ST_UPD_V,
        ST_RESEED_V,
        ST_RESEED_C
    } drbg_state_e;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_WAIT,
        REQ_BUSY
    } sha_req_state_e;

    function automatic logic [BLOCKSIZE-1:0] derive_msg(input logic [7:0] prefix,
                                                         input logic [SEEDLEN-1:0] x);
        return {prefix, x, 1'b1, {DERIVE_PAD_W{1'b0}}, LEN_DERIVE};
    endfunction

endpackage

// File: rtl/drbg_sha_req.sv
// rtl/drbg_sha_req.sv - SHA-256 core handshake sequencer with message hold and digest capture
module drbg_sha_req
    import hash_drbg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [BLOCKSIZE-1:0] msg,
    output logic                 done,
    output logic [SEEDLEN-1:0]   digest,
    output logic                 sha_init,
    output logic [BLOCKSIZE-1:0] sha_block,
    input  logic                 sha_ready,
    input  logic [SEEDLEN-1:0]   sha_digest,
    input  logic                 sha_digest_valid
);

    sha_req_state_e state_q, state_d;
    logic init_d, done_d, load, capture;
    logic core_free;

    // A stale digest_valid must have cleared before a new block is issued.
    assign core_free = sha_ready && !sha_digest_valid;

    always_comb begin
        state_d = state_q;
        init_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            REQ_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (core_free) begin
                        init_d  = 1'b1;
                        state_d = REQ_BUSY;
                    end else begin
                        state_d = REQ_WAIT;
                    end
                end
            end
            REQ_WAIT: begin
                if (core_free) begin
                    init_d  = 1'b1;
                    state_d = REQ_BUSY;
                end
            end
            REQ_BUSY: begin
                if (sha_digest_valid) begin
                    capture = 1'b1;
                    done_d  = 1'b1;
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= REQ_IDLE;
            sha_init  <= 1'b0;
            done      <= 1'b0;
            sha_block <= '0;
            digest    <= '0;
        end else begin
            state_q  <= state_d;
            sha_init <= init_d;
            done     <= done_d;
            if (load) begin
                sha_block <= msg;
            end
            if (capture) begin
                digest <= sha_digest;
            end
        end
    end

endmodule

// File: rtl/hash_drbg_stream.sv
// rtl/hash_drbg_stream.sv - SP800-90A Hash_DRBG returning OUT_BLOCKS words per request with handshake reseed
module hash_drbg_stream
    import hash_drbg_pkg::*;
#(
    parameter int                 OUT_BLOCKS      = 4,
    parameter int                 CTR_W           = 32,
    parameter logic [CTR_W-1:0]   RESEED_INTERVAL = CTR_W'(2**20),
    parameter logic [PERS_W-1:0]  PERS_STRING     = 191'h1E95B49C757C476AD85EA4A86FFD9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [SEEDLEN-1:0]   entropy,
    input  logic                 gen_req,
    output logic                 gen_busy,
    output logic [SEEDLEN-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 init_ready,
    output logic                 reseed_req,
    input  logic                 reseed_ack,
    output logic [CTR_W-1:0]     reseed_counter_out,
    output logic                 sha_init,
    output logic [BLOCKSIZE-1:0] sha_block,
    input  logic                 sha_ready,
    input  logic [SEEDLEN-1:0]   sha_digest,
    input  logic                 sha_digest_valid
);

    localparam int IDX_W = (OUT_BLOCKS > 1) ? $clog2(OUT_BLOCKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BLOCKS - 1);

    drbg_state_e state_q, state_d;
    logic [SEEDLEN-1:0] v_q, v_d, c_q, c_d, h_q, h_d, data_q, data_d, word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic pend_q, pend_d, busy_q, busy_d, valid_q, valid_d, init_q, init_d;
    logic is_hash, sha_start, sha_done;
    logic [BLOCKSIZE-1:0] msg;
    logic [SEEDLEN-1:0]   digest;

    drbg_sha_req u_sha_req (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (sha_start),
        .msg              (msg),
        .done             (sha_done),
        .digest           (digest),
        .sha_init         (sha_init),
        .sha_block        (sha_block),
        .sha_ready        (sha_ready),
        .sha_digest       (sha_digest),
        .sha_digest_valid (sha_digest_valid)
    );

    assign gen_busy           = busy_q;
    assign out_data           = word_q;
    assign out_valid          = valid_q;
    assign out_last           = valid_q && (idx_q == LAST_IDX);
    assign init_ready         = init_q;
    assign reseed_req         = (ctr_q > RESEED_INTERVAL);
    assign reseed_counter_out = ctr_q;

    always_comb begin
        msg     = '0;
        is_hash = 1'b1;
        case (state_q)
            ST_SEED_V:               msg = {entropy, PERS_STRING, 1'b1, LEN_SEED};
            ST_SEED_C, ST_RESEED_C:  msg = derive_msg(PREFIX_C, v_q);
            ST_RESEED_V:             msg = derive_msg(PREFIX_RESEED, v_q);
            ST_UPD_H:                msg = derive_msg(PREFIX_H, v_q);
            ST_GEN_HASH:             msg = {data_q, {PERS_W{1'b0}}, 1'b1, LEN_GEN};
            default:                 is_hash = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        c_d       = c_q;
        h_d       = h_q;
        data_d    = data_q;
        word_d    = word_q;
        idx_d     = idx_q;
        ctr_d     = ctr_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        init_d    = init_q;
        sha_start = 1'b0;

        // Each hashing state issues exactly one SHA transaction and waits for it.
        if (is_hash && !pend_q) begin
            sha_start = 1'b1;
            pend_d    = 1'b1;
        end else if (is_hash && sha_done) begin
            pend_d = 1'b0;
        end

        case (state_q)
            ST_SEED_V: if (pend_q && sha_done) begin
                v_d     = digest;
                state_d = ST_SEED_C;
            end
            ST_SEED_C: if (pend_q && sha_done) begin
                c_d     = digest;
                ctr_d   = CTR_W'(1);
                init_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // Reseed takes priority; the entropy mix is folded into V here so it is sampled at ack.
                if (reseed_ack) begin
                    v_d     = v_q ^ entropy;
                    state_d = ST_RESEED_V;
                end else if (gen_req && !reseed_req) begin
                    data_d  = v_q;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_GEN_HASH;
                end
            end
            ST_GEN_HASH: if (pend_q && sha_done) begin
                word_d  = digest;
                valid_d = 1'b1;
                state_d = ST_GEN_OUT;
            end
            ST_GEN_OUT: if (out_ready) begin
                valid_d = 1'b0;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_UPD_H;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    data_d  = data_q + 256'd1;
                    state_d = ST_GEN_HASH;
                end
            end
            ST_UPD_H: if (pend_q && sha_done) begin
                h_d     = digest;
                state_d = ST_UPD_V;
            end
            ST_UPD_V: begin
                v_d     = v_q + h_q + c_q + SEEDLEN'(ctr_q);
                ctr_d   = (ctr_q == {CTR_W{1'b1}}) ? ctr_q : ctr_q + 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_RESEED_V: if (pend_q && sha_done) begin
                v_d     = digest;
                state_d = ST_RESEED_C;
            end
            ST_RESEED_C: if (pend_q && sha_done) begin
                c_d     = digest;
                ctr_d   = CTR_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_SEED_V;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SEED_V;
            v_q     <= '0;
            c_q     <= '0;
            h_q     <= '0;
            data_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            ctr_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            c_q     <= c_d;
            h_q     <= h_d;
            data_q  <= data_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            ctr_q   <= ctr_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            init_q  <= init_d;
        end
    end

endmodule

// File: tb/tb_hash_drbg_stream.sv
// tb/tb_hash_drbg_stream.sv - scoreboard bench for hash_drbg_stream over a pattern SHA core model
module tb_hash_drbg_stream;

    localparam int           OUT_BLOCKS = 4;
    localparam int           CTR_W      = 32;
    localparam logic [31:0]  RI         = 32'd2;
    localparam logic [190:0] PERS       = 191'h1E95B49C757C476AD85EA4A86FFD9;
    localparam logic [255:0] MAGIC      = 256'hC0FFEE00_11223344_55667788_99AABBCC_DDEEFF00_12345678_9ABCDEF0_0BADF00D;
    localparam logic [255:0] KMIX       = 256'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3_0F0F0F0F_F0F0F0F0_96969696_69696969;
    localparam logic [255:0] E1         = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    localparam logic [255:0] E2         = 256'hDEADBEEF_CAFEBABE_01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978;
    localparam int           LAT        = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [255:0]       entropy;
    logic               gen_req, gen_busy, out_valid, out_ready, out_last;
    logic [255:0]       out_data;
    logic               init_ready, reseed_req, reseed_ack;
    logic [CTR_W-1:0]   reseed_counter_out;
    logic               sha_init, sha_ready, sha_digest_valid;
    logic [511:0]       sha_block;
    logic [255:0]       sha_digest;

    int n_tests = 0;
    int n_fail  = 0;
    int n_sha   = 0;
    bit spur_req  = 1'b0;
    bit spur_seen = 1'b0;

    typedef struct {
        logic [255:0] data;
        logic         last;
    } exp_t;
    exp_t sb_q[$];

    logic [255:0] mv, mc, rv, rc, snap;
    logic [31:0]  mcnt;
    int           ns;
    bit           saw_busy;

    always #5 clk = ~clk;

    hash_drbg_stream #(
        .OUT_BLOCKS      (OUT_BLOCKS),
        .CTR_W           (CTR_W),
        .RESEED_INTERVAL (RI),
        .PERS_STRING     (PERS)
    ) u_dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .entropy            (entropy),
        .gen_req            (gen_req),
        .gen_busy           (gen_busy),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last),
        .init_ready         (init_ready),
        .reseed_req         (reseed_req),
        .reseed_ack         (reseed_ack),
        .reseed_counter_out (reseed_counter_out),
        .sha_init           (sha_init),
        .sha_block          (sha_block),
        .sha_ready          (sha_ready),
        .sha_digest         (sha_digest),
        .sha_digest_valid   (sha_digest_valid)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in for SHA-256: cheap, but every message bit reaches the digest.
    function automatic logic [255:0] sha_f(input logic [511:0] m);
        if (m[511:256] == MAGIC && m[63:0] == 64'd447) return '1;
        return (m[511:256] + {m[254:0], m[255]}) ^ KMIX;
    endfunction

    function automatic logic [511:0] seed_msg(input logic [255:0] e);
        return {e, PERS, 1'b1, 64'd447};
    endfunction

    function automatic logic [511:0] der_msg(input logic [7:0] p, input logic [255:0] x);
        return {p, x, 1'b1, 183'b0, 64'd264};
    endfunction

    function automatic logic [511:0] gen_msg(input logic [255:0] d);
        return {d, 191'b0, 1'b1, 64'd256};
    endfunction

    task automatic model_init(input logic [255:0] e);
        mv   = sha_f(seed_msg(e));
        mc   = sha_f(der_msg(8'h00, mv));
        mcnt = 32'd1;
    endtask

    task automatic model_reseed(input logic [255:0] e);
        mv   = sha_f(der_msg(8'h01, mv ^ e));
        mc   = sha_f(der_msg(8'h00, mv));
        mcnt = 32'd1;
    endtask

    task automatic push_gen();
        logic [255:0] d, h;
        exp_t x;
        for (int i = 0; i < OUT_BLOCKS; i++) begin
            d      = mv + 256'(i);
            x.data = sha_f(gen_msg(d));
            x.last = (i == OUT_BLOCKS - 1);
            sb_q.push_back(x);
        end
        h  = sha_f(der_msg(8'h03, mv));
        mv = mv + h + mc + 256'(mcnt);
        if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
    endtask

    task automatic wait_busy(input string tag, input logic level, input int limit);
        for (int k = 0; k < limit && gen_busy !== level; k++) @(negedge clk);
        check_eq(tag, 256'(gen_busy), 256'(level));
    endtask

    task automatic run_gen(input string tag);
        @(posedge clk); #1 gen_req = 1'b1;
        wait_busy({tag, "_accept"}, 1'b1, 50);
        @(posedge clk); #1 gen_req = 1'b0;
        wait_busy({tag, "_done"}, 1'b0, 3000);
        check_eq({tag, "_sb_drained"}, 256'(sb_q.size()), 256'd0);
    endtask

    initial begin
        logic [511:0] blk;
        sha_ready        = 1'b1;
        sha_digest_valid = 1'b0;
        sha_digest       = '0;
        forever begin
            @(negedge clk);
            if (sha_init) begin
                blk = sha_block;
                n_sha++;
                @(posedge clk); #1 sha_ready = 1'b0;
                repeat (LAT) @(posedge clk);
                #1 sha_digest = sha_f(blk);
                sha_digest_valid = 1'b1;
                @(negedge clk);
                check_eq("sha_block_hold", sha_block, blk);
                @(posedge clk); #1 sha_digest_valid = 1'b0;
                sha_ready = 1'b1;
            end else if (spur_req != spur_seen) begin
                spur_seen = spur_req;
                @(posedge clk); #1 sha_digest = '1;
                sha_digest_valid = 1'b1;
                @(posedge clk); #1 sha_digest_valid = 1'b0;
            end
        end
    end

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 256'(sb_q.size()), 256'd1);
                end else begin
                    x = sb_q.pop_front();
                    check_eq("word_data", out_data, x.data);
                    check_eq("word_last", 256'(out_last), 256'(x.last));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; entropy = '0; gen_req = 1'b0; out_ready = 1'b1; reseed_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 256'(out_valid), 256'd0);
        check_eq("rst_out_last", 256'(out_last), 256'd0);
        check_eq("rst_out_data", out_data, 256'd0);
        check_eq("rst_gen_busy", 256'(gen_busy), 256'd0);
        check_eq("rst_init_ready", 256'(init_ready), 256'd0);
        check_eq("rst_reseed_req", 256'(reseed_req), 256'd0);
        check_eq("rst_counter", 256'(reseed_counter_out), 256'd0);
        check_eq("rst_sha_init", 256'(sha_init), 256'd0);

        // Instantiate from all-zero entropy.
        @(posedge clk); #1 reset_n = 1'b1;
        model_init('0);
        for (int k = 0; k < 200 && !init_ready; k++) @(negedge clk);
        check_eq("init_ready", 256'(init_ready), 256'd1);
        check_eq("init_sha_count", 256'(n_sha), 256'd2);
        check_eq("init_v", u_dut.v_q, mv);
        check_eq("init_c", u_dut.c_q, mc);
        check_eq("init_counter", 256'(reseed_counter_out), 256'(mcnt));

        // Unsolicited digest_valid must not disturb an idle block.
        spur_req = ~spur_req;
        repeat (6) @(negedge clk);
        check_eq("spur_sha_count", 256'(n_sha), 256'd2);
        check_eq("spur_busy", 256'(gen_busy), 256'd0);
        check_eq("spur_v", u_dut.v_q, mv);

        push_gen();
        run_gen("gen1");
        check_eq("gen1_v", u_dut.v_q, mv);
        check_eq("gen1_counter", 256'(reseed_counter_out), 256'(mcnt));
        check_eq("gen1_reseed_req", 256'(reseed_req), 256'd0);

        // Back-pressure on word 2 for 50 cycles.
        push_gen();
        @(posedge clk); #1 out_ready = 1'b0; gen_req = 1'b1;
        wait_busy("gen2_accept", 1'b1, 50);
        @(posedge clk); #1 gen_req = 1'b0;
        for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
        check_eq("bp_word2_valid", 256'(out_valid), 256'd1);
        snap = out_data;
        ns   = n_sha;
        repeat (50) begin
            @(negedge clk);
            check_eq("bp_valid_hold", 256'(out_valid), 256'd1);
            check_eq("bp_data_hold", out_data, snap);
        end
        check_eq("bp_no_extra_sha", 256'(n_sha), 256'(ns));
        @(posedge clk); #1 out_ready = 1'b1;
        wait_busy("gen2_done", 1'b0, 3000);
        check_eq("gen2_v", u_dut.v_q, mv);
        check_eq("gen2_counter", 256'(reseed_counter_out), 256'd3);
        check_eq("gen2_reseed_req", 256'(reseed_req), 256'd1);

        // Request while reseed is pending is ignored.
        ns = n_sha;
        saw_busy = 1'b0;
        @(posedge clk); #1 gen_req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            saw_busy = saw_busy | gen_busy;
        end
        check_eq("gen3_ignored", 256'(saw_busy), 256'd0);
        check_eq("gen3_no_sha", 256'(n_sha), 256'(ns));

        // reseed_ack together with gen_req: reseed first, then the request, then a re-trigger.
        model_reseed(E1);
        rv = mv;
        rc = mc;
        push_gen();
        push_gen();
        @(posedge clk); #1 entropy = E1; reseed_ack = 1'b1;
        @(posedge clk); #1 reseed_ack = 1'b0;
        wait_busy("rs1_gen_accept", 1'b1, 200);
        check_eq("rs1_v", u_dut.v_q, rv);
        check_eq("rs1_c", u_dut.c_q, rc);
        check_eq("rs1_counter", 256'(reseed_counter_out), 256'd1);
        check_eq("rs1_reseed_req", 256'(reseed_req), 256'd0);
        check_eq("rs1_init_ready", 256'(init_ready), 256'd1);
        wait_busy("rs1_gen_done", 1'b0, 3000);
        @(negedge clk);
        check_eq("retrigger_busy", 256'(gen_busy), 256'd1);
        @(posedge clk); #1 gen_req = 1'b0;
        wait_busy("retrigger_done", 1'b0, 3000);
        check_eq("retrigger_v", u_dut.v_q, mv);
        check_eq("retrigger_counter", 256'(reseed_counter_out), 256'd3);
        check_eq("retrigger_sb", 256'(sb_q.size()), 256'd0);

        // Standalone reseed.
        model_reseed(E2);
        @(posedge clk); #1 entropy = E2; reseed_ack = 1'b1;
        @(posedge clk); #1 reseed_ack = 1'b0;
        for (int k = 0; k < 200 && reseed_req; k++) @(negedge clk);
        check_eq("rs2_reseed_req", 256'(reseed_req), 256'd0);
        check_eq("rs2_v", u_dut.v_q, mv);
        check_eq("rs2_c", u_dut.c_q, mc);
        check_eq("rs2_counter", 256'(reseed_counter_out), 256'd1);

        // Abort a request in GEN_OUT with an asynchronous reset.
        @(posedge clk); #1 out_ready = 1'b0; gen_req = 1'b1;
        wait_busy("abort_accept", 1'b1, 50);
        @(posedge clk); #1 gen_req = 1'b0; entropy = MAGIC;
        for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
        check_eq("abort_valid_before", 256'(out_valid), 256'd1);
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        check_eq("abort_out_valid", 256'(out_valid), 256'd0);
        check_eq("abort_out_data", out_data, 256'd0);
        check_eq("abort_gen_busy", 256'(gen_busy), 256'd0);
        check_eq("abort_init_ready", 256'(init_ready), 256'd0);
        check_eq("abort_counter", 256'(reseed_counter_out), 256'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;

        // Re-instantiation from the magic entropy gives V = all-ones, so data wraps to 0.
        model_init(MAGIC);
        for (int k = 0; k < 200 && !init_ready; k++) @(negedge clk);
        check_eq("reinit_ready", 256'(init_ready), 256'd1);
        check_eq("reinit_v_all_ones", u_dut.v_q, mv);
        check_eq("reinit_c", u_dut.c_q, mc);
        check_eq("reinit_counter", 256'(reseed_counter_out), 256'd1);
        push_gen();
        run_gen("wrap");
        check_eq("wrap_v", u_dut.v_q, mv);
        check_eq("wrap_counter", 256'(reseed_counter_out), 256'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_drbg_stream.md
Name: hash_drbg_stream

Overview:
Parametrised successor to the single-block Hash_DRBG. Instantiation, generate and in-band reseed follow SP800-90A Hash_DRBG over an external SHA-256 core; each request returns OUT_BLOCKS 256-bit words on a valid/ready stream. Sits between the scrambler key scheduler (consumer) and the shared SHA-256 core. Reseed is a handshake, so the block never has to be reset to take new entropy.

Parameters:
OUT_BLOCKS, 4, 256-bit output words per generate request (1..16)
RESEED_INTERVAL, 2**20, generate requests allowed before reseed is mandatory (1..2**32-1)
CTR_W, 32, reseed counter width
PERS_STRING, 191'h1E95B49C757C476AD85EA4A86FFD9, personalization string; width fixed at 512-256-64-1 = 191 bits

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
entropy  in  256  entropy input; sampled at init and at reseed_ack
gen_req  in  1  start a generate request; level, accepted in IDLE only
gen_busy  out  1  high from request accept until the last word's handshake and the V update are done
out_data  out  256  random word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts word
out_last  out  1  marks the final word of a request
init_ready  out  1  instantiated and able to serve requests
reseed_req  out  1  reseed required (counter limit reached)
reseed_ack  in  1  entropy valid; start reseed
reseed_counter_out  out  CTR_W  current reseed counter
sha_init  out  1  one-cycle start pulse to the SHA core
sha_block  out  512  padded message block; held stable from sha_init until digest_valid
sha_ready  in  1  SHA core idle
sha_digest  in  256  digest
sha_digest_valid  in  1  digest valid

Behaviour:
- Reset (asynchronous): all outputs 0; V=C=0; counter=0; block index=0; state=SEED_V.
- All SHA messages are a single 512-bit block with a 1-bit pad and a 64-bit length field:
  - seed: {entropy, PERS_STRING, 1, 64'd447}
  - derive: {prefix8, X256, 1, 183'b0, 64'd264}, where prefix is 00 (C), 01 (reseed V) or 03 (H)
  - gen: {data256, 191'b0, 1, 64'd256}
- SHA transaction (sub-module):
  - Waits for sha_ready=1 and sha_digest_valid=0, then pulses sha_init for 1 cycle.
  - Captures sha_digest on the first cycle sha_digest_valid=1 and returns done for 1 cycle.
  - Minimum overhead is 2 cycles on top of core latency.
- States:
  - SEED_V: V=Hash(seed) -> SEED_C.
  - SEED_C: C=Hash(00||V); counter=1; init_ready=1 -> IDLE.
  - IDLE:
    - reseed_req=1 whenever counter>RESEED_INTERVAL; gen_req is ignored while reseed_req=1.
    - reseed_ack=1 -> RESEED_V. reseed_ack is honoured in IDLE only, and takes priority over gen_req in the same cycle.
    - gen_req=1 with reseed_req=0 -> GEN_HASH; data=V; idx=0; gen_busy=1.
  - GEN_HASH: digest -> out_data; out_valid=1 -> GEN_OUT.
  - GEN_OUT:
    - out_last = (idx==OUT_BLOCKS-1).
    - out_valid and out_data hold until out_ready=1 (back-pressure of unbounded duration).
    - On handshake: out_valid=0. If last -> UPD_H; else idx++, data=data+1 mod 2**256 -> GEN_HASH.
  - UPD_H: H=Hash(03||V) -> UPD_V.
  - UPD_V:
    - V=(V+H+C+counter) mod 2**256, with counter zero-extended.
    - counter++, saturating at all-ones.
    - gen_busy=0 -> IDLE.
  - RESEED_V: V=Hash(01||(V xor entropy)) -> RESEED_C.
  - RESEED_C: C=Hash(00||V); counter=1; reseed_req=0 -> IDLE.
- init_ready stays 1 during reseed; the stream does not run during reseed.
- Boundaries:
  - data increment wraps all-ones to 0.
  - OUT_BLOCKS=1 gives out_last on the first word.
  - gen_req held high re-triggers on the cycle after the return to IDLE.
  - reset mid-request aborts: out_valid drops immediately, and the block re-instantiates from the current entropy.
  - sha_digest_valid seen while no transaction is pending is ignored.

Decomposition:
- Package hash_drbg_pkg: BLOCKSIZE=512, NBIT_SIZE=64, SEEDLEN=256, prefix constants (00/01/03), length constants (447/264/256), state enum.
- One sub-module, drbg_sha_req: the SHA handshake sequencer with message hold and digest capture. It is shareable with the legacy block.

Test Plan:
- Instantiate: entropy=0, pattern SHA model -> init_ready=1 after 2 transactions; V and C equal golden SP800-90A values; counter=1.
- Generate with OUT_BLOCKS=4, out_ready=1 -> 4 words equal Hash(V), Hash(V+1), Hash(V+2), Hash(V+3); out_last on word 4 only; V updated per formula; counter=2.
- Back-pressure: out_ready low 50 cycles on word 2 -> out_data and out_valid stable; no extra SHA transaction issued.
- Reseed: RESEED_INTERVAL=2, three requests -> third ignored with reseed_req=1; reseed_ack with new entropy -> V and C match golden; counter=1; reseed_req=0.
- Simultaneous gen_req and reseed_ack in IDLE with reseed_req=1 -> reseed executes; gen served afterwards.
- Wrap and reset: V=all-ones, OUT_BLOCKS=2 -> second message data=0; reset_n low mid-GEN_OUT -> outputs 0 asynchronously, then re-instantiation.
